pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the 16-bit five-stage CPU core.
- Generates stall/flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, which hold the decoded immediate and operand selects between stages.
- Arbitrates the single shared instruction/data RAM bus between IF and MEM.
- Detects load-use hazards and branch-redirect flushes; provides a memory-wait watchdog and a stall-cycle counter.

Parameters:
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before timeout; 0 disables the watchdog
REG_ADDR_W, 4, register-address width (8 GPRs plus SP/IH/T/RA)
CNT_W, 16, stall-cycle counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
id_rs_addr  in  REG_ADDR_W  source register A of the instruction in ID
id_rs_used  in  1  ID instruction reads rs
id_rt_addr  in  REG_ADDR_W  source register B of the instruction in ID
id_rt_used  in  1  ID instruction reads rt
ex_mem_read  in  1  instruction in EX is a load
ex_wb_en  in  1  instruction in EX writes a register
ex_wb_addr  in  REG_ADDR_W  destination register of EX
id_branch_taken  in  1  branch/jump resolved taken in ID
mem_req  in  1  MEM stage needs the shared RAM bus
mem_ready  in  1  RAM completes the current access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  load NOP into IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  load NOP into ID/EX
ex_mem_stall  out  1  hold EX/MEM
mem_wb_flush  out  1  load NOP into MEM/WB
bus_sel_mem  out  1  1 = RAM bus granted to MEM, 0 = to IF
mem_timeout  out  1  sticky watchdog error
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Register reset values (rst=0): state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0.
- Outputs while rst=0: if_id_flush=id_ex_flush=mem_wb_flush=1; all stall outputs 0; bus_sel_mem=0.
- Structure: state, wait_cnt, mem_timeout and stall_cycles are registered. Stall, flush and bus_sel outputs are combinational from state and inputs (zero latency).
- load_use = ex_mem_read & ex_wb_en & ((id_rs_used & rs==ex_wb_addr) | (id_rt_used & rt==ex_wb_addr)).
- State RUN, priority order:
  1. mem_req & mem_ready: single-cycle MEM access. bus_sel_mem=1, pc_stall=1, if_id_flush=1; the rest of the pipe advances; stay in RUN.
  2. mem_req & !mem_ready: bus_sel_mem=1; pc/if_id/id_ex/ex_mem stall=1; mem_wb_flush=1; wait_cnt<=1; go to MEM_WAIT.
  3. load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble). A simultaneous id_branch_taken is ignored this cycle and re-evaluated next cycle.
  4. id_branch_taken: if_id_flush=1 only.
  5. Otherwise all outputs 0.
- State MEM_WAIT:
  - mem_req & mem_ready: outputs as RUN case 1; wait_cnt<=0; go to RUN.
  - mem_req & !mem_ready: outputs as RUN case 2; wait_cnt++.
  - If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT: go to TIMEOUT and set mem_timeout.
  - !mem_req (abort): go to RUN and evaluate RUN rules combinationally in the same cycle; wait_cnt<=0.
- State TIMEOUT: pc/if_id/id_ex/ex_mem stall=1, mem_wb_flush=1, bus_sel_mem=0, mem_timeout=1. Exits only on reset.
- stall_cycles: increments on each clk edge where pc_stall=1; holds at 2^CNT_W-1 (no wrap).
- Reset mid-access: immediate return to RUN, bus handed back to IF, counters cleared.

Decomposition:
- define.v holds PIPE_ST_RUN/PIPE_ST_MEM_WAIT/PIPE_ST_TIMEOUT (2-bit encodings), REG_ADDR_BUS, and a NOP-flush convention shared with the pipeline registers.
- One sub-module: hazard_detect (combinational load_use compare), reusable by a future forwarding unit. The FSM and counters stay in pipe_hazard_ctrl.

Test Plan:
- Reset sequence: rst low for 3 cycles, then high -> all flushes 1 while low; afterwards all outputs 0, stall_cycles=0.
- Load-use: ex_mem_read=1, ex_wb_en=1, ex_wb_addr=3, id_rs_addr=3, id_rs_used=1, id_branch_taken=1 -> cycle 1: pc_stall, if_id_stall, id_ex_flush=1 and if_id_flush=0; stall_cycles=1.
- Multi-cycle load: mem_req=1 with mem_ready low for 3 cycles then high -> 3 cycles of full stall plus mem_wb_flush with bus_sel_mem=1; ready cycle shows pc_stall=1, if_id_flush=1, ex_mem_stall=0; stall_cycles=4.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held -> mem_timeout rises after the 4th wait cycle and stays set, bus_sel_mem=0; holding mem_ready=1 afterwards has no effect until rst.
- Abort: enter MEM_WAIT, drop mem_req while id_branch_taken=1 -> same cycle if_id_flush=1, no stalls; state returns to RUN.
- Saturation: CNT_W=4, hold load_use for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline control unit:
// FSM state encodings and the stall/flush strobe bundle with its fixed patterns.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        PIPE_ST_RUN      = 2'd0,
        PIPE_ST_MEM_WAIT = 2'd1,
        PIPE_ST_TIMEOUT  = 2'd2
    } pipe_st_e;

    // A flush strobe makes the pipeline register load its NOP encoding
    // (all selects zero, no write-back) on the next edge; a stall holds it.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
        logic bus_sel_mem;
    } pipe_strobes_t;

    localparam pipe_strobes_t STROBES_IDLE = '0;

    localparam pipe_strobes_t STROBES_RESET = '{
        if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_flush: 1'b1, default: 1'b0
    };

    localparam pipe_strobes_t STROBES_MEM_HIT = '{
        pc_stall: 1'b1, if_id_flush: 1'b1, bus_sel_mem: 1'b1, default: 1'b0
    };

    localparam pipe_strobes_t STROBES_MEM_WAIT = '{
        pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_stall: 1'b1, ex_mem_stall: 1'b1,
        mem_wb_flush: 1'b1, bus_sel_mem: 1'b1, default: 1'b0
    };

    localparam pipe_strobes_t STROBES_TIMEOUT = '{
        pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_stall: 1'b1, ex_mem_stall: 1'b1,
        mem_wb_flush: 1'b1, default: 1'b0
    };

    localparam pipe_strobes_t STROBES_LOAD_USE = '{
        pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_flush: 1'b1, default: 1'b0
    };

    localparam pipe_strobes_t STROBES_BRANCH = '{
        if_id_flush: 1'b1, default: 1'b0
    };

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-control-unit signal bundle: hazard sources and RAM handshake in,
// stall/flush strobes, bus grant and status out.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic                  id_rs_used;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic                  id_rt_used;
    logic                  ex_mem_read;
    logic                  ex_wb_en;
    logic [REG_ADDR_W-1:0] ex_wb_addr;
    logic                  id_branch_taken;
    logic                  mem_req;
    logic                  mem_ready;

    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  if_id_flush;
    logic                  id_ex_stall;
    logic                  id_ex_flush;
    logic                  ex_mem_stall;
    logic                  mem_wb_flush;
    logic                  bus_sel_mem;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cycles;

    // Pipeline datapath side.
    modport master (
        output id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
               ex_mem_read, ex_wb_en, ex_wb_addr, id_branch_taken,
               mem_req, mem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, bus_sel_mem, mem_timeout, stall_cycles
    );

    // Control unit side.
    modport slave (
        input  id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
               ex_mem_read, ex_wb_en, ex_wb_addr, id_branch_taken,
               mem_req, mem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, bus_sel_mem, mem_timeout, stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID. Kept standalone so a forwarding unit can reuse it.
module hazard_detect #(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic                  id_rs_used,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_rt_used,
    input  logic                  ex_mem_read,
    input  logic                  ex_wb_en,
    input  logic [REG_ADDR_W-1:0] ex_wb_addr,
    output logic                  load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = id_rs_used && (id_rs_addr == ex_wb_addr);
    assign rt_hit   = id_rt_used && (id_rt_addr == ex_wb_addr);
    assign load_use = ex_mem_read && ex_wb_en && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: shared RAM bus arbitration, load-use bubbles, branch
// flushes, memory-wait watchdog and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int REG_ADDR_W  = 4,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int  WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam bit  TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    pipe_st_e          state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

    logic              load_use;
    pipe_strobes_t     run_strobes;
    pipe_strobes_t     strobes;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs_addr  (hz.id_rs_addr),
        .id_rs_used  (hz.id_rs_used),
        .id_rt_addr  (hz.id_rt_addr),
        .id_rt_used  (hz.id_rt_used),
        .ex_mem_read (hz.ex_mem_read),
        .ex_wb_en    (hz.ex_wb_en),
        .ex_wb_addr  (hz.ex_wb_addr),
        .load_use    (load_use)
    );

    // RUN-state priority; also reused when MEM_WAIT aborts, since the RUN
    // rules then apply in that same cycle.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the
        // variable unassigned; otherwise synthesis infers a latch.
        run_strobes = STROBES_IDLE;
        if (hz.mem_req && hz.mem_ready) begin
            run_strobes = STROBES_MEM_HIT;
        end else if (hz.mem_req) begin
            run_strobes = STROBES_MEM_WAIT;
        end else if (load_use) begin
            run_strobes = STROBES_LOAD_USE;
        end else if (hz.id_branch_taken) begin
            run_strobes = STROBES_BRANCH;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        strobes       = STROBES_IDLE;

        case (state_q)
            PIPE_ST_RUN: begin
                strobes = run_strobes;
                if (hz.mem_req && !hz.mem_ready) begin
                    state_d    = PIPE_ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end

            PIPE_ST_MEM_WAIT: begin
                if (!hz.mem_req) begin
                    strobes    = run_strobes;
                    state_d    = PIPE_ST_RUN;
                    wait_cnt_d = '0;
                end else if (hz.mem_ready) begin
                    strobes    = STROBES_MEM_HIT;
                    state_d    = PIPE_ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    strobes = STROBES_MEM_WAIT;
                    if (TIMEOUT_EN && (wait_cnt_q == WAIT_LIMIT)) begin
                        state_d       = PIPE_ST_TIMEOUT;
                        mem_timeout_d = 1'b1;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end

            PIPE_ST_TIMEOUT: begin
                strobes = STROBES_TIMEOUT;
            end

            default: begin
                state_d = PIPE_ST_RUN;
            end
        endcase

        // Held reset drains the pipe with NOPs and hands the bus back to IF.
        if (!rst) begin
            strobes = STROBES_RESET;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (strobes.pc_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q        <= PIPE_ST_RUN;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.pc_stall     = strobes.pc_stall;
    assign hz.if_id_stall  = strobes.if_id_stall;
    assign hz.if_id_flush  = strobes.if_id_flush;
    assign hz.id_ex_stall  = strobes.id_ex_stall;
    assign hz.id_ex_flush  = strobes.id_ex_flush;
    assign hz.ex_mem_stall = strobes.ex_mem_stall;
    assign hz.mem_wb_flush = strobes.mem_wb_flush;
    assign hz.bus_sel_mem  = strobes.bus_sel_mem;
    assign hz.mem_timeout  = mem_timeout_q;
    assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=4:
// each driven cycle pushes its expected outputs, the negedge monitor compares.
module tb_pipe_hazard_ctrl;

    localparam int RA_W = 4;
    localparam int CW   = 4;

    // Strobe vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
    // id_ex_flush, ex_mem_stall, mem_wb_flush, bus_sel_mem.
    localparam logic [7:0] P_IDLE  = 8'b0000_0000;
    localparam logic [7:0] P_RST   = 8'b0010_1010;
    localparam logic [7:0] P_HIT   = 8'b1010_0001;
    localparam logic [7:0] P_MWAIT = 8'b1101_0111;
    localparam logic [7:0] P_TMO   = 8'b1101_0110;
    localparam logic [7:0] P_LU    = 8'b1100_1000;
    localparam logic [7:0] P_BR    = 8'b0010_0000;

    typedef struct packed {
        logic [7:0]    strb;
        logic          tmo;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;

    exp_t          sb_q[$];
    string         tag_q[$];
    logic          exp_tmo;
    logic [CW-1:0] exp_cnt;
    int            n_cmp;
    int            n_err;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(RA_W), .CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .REG_ADDR_W  (RA_W),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t  e;
            string t;
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".strobes"}, 32'({hz.pc_stall, hz.if_id_stall, hz.if_id_flush,
                                        hz.id_ex_stall, hz.id_ex_flush, hz.ex_mem_stall,
                                        hz.mem_wb_flush, hz.bus_sel_mem}), 32'(e.strb));
            check({t, ".mem_timeout"}, 32'(hz.mem_timeout), 32'(e.tmo));
            check({t, ".stall_cycles"}, 32'(hz.stall_cycles), 32'(e.cnt));
        end
    end

    task automatic set_in(input logic [RA_W-1:0] rs, input logic rs_used,
                          input logic [RA_W-1:0] rt, input logic rt_used,
                          input logic mrd, input logic wben, input logic [RA_W-1:0] wba,
                          input logic br, input logic mreq, input logic mrdy);
        hz.id_rs_addr      = rs;
        hz.id_rs_used      = rs_used;
        hz.id_rt_addr      = rt;
        hz.id_rt_used      = rt_used;
        hz.ex_mem_read     = mrd;
        hz.ex_wb_en        = wben;
        hz.ex_wb_addr      = wba;
        hz.id_branch_taken = br;
        hz.mem_req         = mreq;
        hz.mem_ready       = mrdy;
    endtask

    // One cycle: inputs are already applied; record the expected outputs, then
    // advance the stall counter expectation across the coming edge.
    task automatic step(input logic [7:0] s, input string tag);
        if (!rst) exp_cnt = '0;
        sb_q.push_back(exp_t'({s, exp_tmo, exp_cnt}));
        tag_q.push_back(tag);
        @(posedge clk);
        if (rst && s[7] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        exp_tmo = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(P_RST, "rst_hold");
        rst = 1'b1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        exp_tmo = 1'b0;
        exp_cnt = '0;
        rst     = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset: three cycles low, flushes win even with requests present.
        step(P_RST, "rst_c1");
        set_in(3, 1, 0, 0, 1, 1, 3, 1, 1, 0);
        step(P_RST, "rst_c2");
        step(P_RST, "rst_c3");
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(P_IDLE, "rst_after");

        // Load-use on rs beats a simultaneous taken branch, then branch alone.
        set_in(3, 1, 0, 0, 1, 1, 3, 1, 0, 0);
        step(P_LU, "lu_rs_br");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(P_BR, "br_only");
        set_in(2, 0, 5, 1, 1, 1, 5, 0, 0, 0);
        step(P_LU, "lu_rt");
        set_in(5, 1, 0, 0, 1, 0, 5, 0, 0, 0);
        step(P_IDLE, "lu_no_wben");
        set_in(5, 0, 0, 0, 1, 1, 5, 0, 0, 0);
        step(P_IDLE, "lu_rs_unused");
        set_in(5, 1, 0, 0, 0, 1, 5, 0, 0, 0);
        step(P_IDLE, "lu_not_load");
        set_in(15, 1, 0, 0, 1, 1, 15, 0, 0, 0);
        step(P_LU, "lu_addr_max");

        // Multi-cycle load: three wait cycles then completion.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) step(P_MWAIT, "mc_wait");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(P_HIT, "mc_ready");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(P_IDLE, "mc_done");

        // Single-cycle access in RUN outranks load-use.
        set_in(3, 1, 0, 0, 1, 1, 3, 1, 1, 1);
        step(P_HIT, "hit_over_lu");

        // Abort from MEM_WAIT with a taken branch, then with a load-use.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(P_MWAIT, "ab_enter");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(P_BR, "ab_branch");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(P_MWAIT, "ab_enter2");
        set_in(4, 1, 0, 0, 1, 1, 4, 1, 0, 0);
        step(P_LU, "ab_loaduse");

        // Wait counter restarts after the abort: four waits stay below the limit.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (4) step(P_MWAIT, "restart_wait");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(P_HIT, "restart_ready");

        // Reset in the middle of an access returns the bus to IF.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) step(P_MWAIT, "mid_wait");
        rst = 1'b0;
        step(P_RST, "mid_rst");
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(P_IDLE, "mid_after");

        // Watchdog: entry cycle plus four MEM_WAIT cycles, then sticky TIMEOUT.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (5) step(P_MWAIT, "tmo_wait");
        exp_tmo = 1'b1;
        repeat (2) step(P_TMO, "tmo_hold");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        repeat (2) step(P_TMO, "tmo_ready");
        set_in(3, 1, 0, 0, 1, 1, 3, 1, 0, 0);
        step(P_TMO, "tmo_other");
        rst     = 1'b0;
        exp_tmo = 1'b0;
        step(P_RST, "tmo_rst");
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(P_IDLE, "tmo_cleared");

        // Counter saturation at 2^CNT_W-1.
        set_in(7, 1, 0, 0, 1, 1, 7, 0, 0, 0);
        repeat (20) step(P_LU, "sat_lu");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(P_IDLE, "sat_final");

        @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("sat_value", 32'(hz.stall_cycles), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
